// File: rtl/load_sequencer.sv
// Load-then-readout sequencer: pulses a load strobe per selected register, then
// presents each selected register on the readout mux for HOLD_CYCLES cycles.
module load_sequencer #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] mask,
  input  logic       abort,
  output logic       ld_a,
  output logic       ld_b,
  output logic       ld_c,
  output logic [1:0] output_sel,
  output logic       out_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    StIdle, StLoadA, StLoadB, StLoadC, StShowA, StShowB, StShowC, StDone
  } state_e;

  localparam logic [3:0] HoldLast = 4'(HOLD_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic [2:0] mask_q, mask_d;

  function automatic state_e first_show(input logic [2:0] m);
    if (m[0])      return StShowA;
    else if (m[1]) return StShowB;
    else if (m[2]) return StShowC;
    else           return StDone;
  endfunction

  function automatic state_e first_load(input logic [2:0] m);
    if (m[0])      return StLoadA;
    else if (m[1]) return StLoadB;
    else if (m[2]) return StLoadC;
    else           return first_show(m);
  endfunction

  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    mask_d  = mask_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mask_d  = mask;
          state_d = first_load(mask);
        end
      end
      StLoadA: state_d = mask_q[1] ? StLoadB : mask_q[2] ? StLoadC : first_show(mask_q);
      StLoadB: state_d = mask_q[2] ? StLoadC : first_show(mask_q);
      StLoadC: state_d = first_show(mask_q);
      StShowA, StShowB, StShowC: begin
        if (hold_q == HoldLast) begin
          if (state_q == StShowA)      state_d = mask_q[1] ? StShowB : mask_q[2] ? StShowC : StDone;
          else if (state_q == StShowB) state_d = mask_q[2] ? StShowC : StDone;
          else                         state_d = StDone;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      StDone: state_d = StIdle;
    endcase
    // Abort overrides whatever transition was computed above.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      hold_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      mask_q  <= mask_d;
    end
  end

  // Outputs decode from state only, so reset takes effect on them immediately.
  always_comb begin
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    ld_c       = 1'b0;
    output_sel = 2'b11;
    out_valid  = 1'b0;
    busy       = (state_q != StIdle);
    done       = 1'b0;
    case (state_q)
      StLoadA: ld_a = 1'b1;
      StLoadB: ld_b = 1'b1;
      StLoadC: ld_c = 1'b1;
      StShowA: begin output_sel = 2'b00; out_valid = 1'b1; end
      StShowB: begin output_sel = 2'b01; out_valid = 1'b1; end
      StShowC: begin output_sel = 2'b10; out_valid = 1'b1; end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_sequencer.sv
// Bench for load_sequencer: expected per-cycle output vectors are queued when a
// sequence is started and popped one per cycle against the DUT outputs.
module tb_load_sequencer;

  localparam int unsigned HOLD = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [2:0] mask = 3'b000;
  logic       abort = 1'b0;
  logic       ld_a, ld_b, ld_c, out_valid, busy, done;
  logic [1:0] output_sel;

  int compared = 0;
  int mismatched = 0;

  // {ld_a, ld_b, ld_c, output_sel, out_valid, busy, done}
  logic [7:0] exp_q[$];
  logic [7:0] obs;
  logic [7:0] exp_v;

  localparam logic [7:0] VecIdle = 8'b000_11_0_0_0;
  localparam logic [7:0] VecDone = 8'b000_11_0_1_1;

  assign obs = {ld_a, ld_b, ld_c, output_sel, out_valid, busy, done};

  always #5 clk = ~clk;

  load_sequencer #(.HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mask      (mask),
    .abort     (abort),
    .ld_a      (ld_a),
    .ld_b      (ld_b),
    .ld_c      (ld_c),
    .output_sel(output_sel),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  task automatic push_run(input logic [2:0] m);
    if (m[0]) exp_q.push_back(8'b100_11_0_1_0);
    if (m[1]) exp_q.push_back(8'b010_11_0_1_0);
    if (m[2]) exp_q.push_back(8'b001_11_0_1_0);
    for (int b = 0; b < 3; b++)
      if (m[b]) for (int h = 0; h < int'(HOLD); h++) exp_q.push_back({3'b000, 2'(b), 3'b110});
    exp_q.push_back(VecDone);
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(VecIdle);
  endtask

  // Drives start at the current cycle so the next edge is "edge 0"; returns in cycle 1.
  task automatic kick(input logic [2:0] m);
    start = 1'b1;
    mask  = m;
    @(posedge clk); #1;
    start = 1'b0;
    mask  = 3'b000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    compared++;
    if (obs !== VecIdle) begin
      mismatched++;
      $display("FAIL reset_async: got %b expected %b", obs, VecIdle);
    end
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    compared++;
    if (obs !== VecIdle) begin
      mismatched++;
      $display("FAIL reset_release: got %b expected %b", obs, VecIdle);
    end
  endtask

  task automatic test_mask(input logic [2:0] m);
    exp_q.delete();
    push_run(m);
    push_idle(2);
    kick(m);
    for (int i = 1; exp_q.size() > 0; i++) begin
      exp_v = exp_q.pop_front();
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL mask_%b cycle %0d: got %b expected %b", m, i, obs, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_start_ignored();
    exp_q.delete();
    push_run(3'b111);
    push_idle(1);
    push_run(3'b001);
    push_idle(1);
    kick(3'b111);
    for (int i = 1; exp_q.size() > 0; i++) begin
      exp_v = exp_q.pop_front();
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL start_ignored cycle %0d: got %b expected %b", i, obs, exp_v);
      end
      if (i == 5) begin start = 1'b1; mask = 3'b010; end
      if (i == 6) start = 1'b0;
      if (i == 10) begin start = 1'b1; mask = 3'b001; end
      if (i == 12) begin start = 1'b0; mask = 3'b000; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_abort();
    exp_q.delete();
    push_run(3'b111);
    while (exp_q.size() > 6) void'(exp_q.pop_back());
    push_idle(3);
    kick(3'b111);
    for (int i = 1; exp_q.size() > 0; i++) begin
      exp_v = exp_q.pop_front();
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL abort cycle %0d: got %b expected %b", i, obs, exp_v);
      end
      abort = (i == 6);
      @(posedge clk); #1;
    end
    abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_q.delete();
    push_run(3'b111);
    kick(3'b111);
    for (int i = 1; i <= 7; i++) begin
      exp_v = exp_q.pop_front();
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL reset_mid cycle %0d: got %b expected %b", i, obs, exp_v);
      end
      if (i < 7) begin @(posedge clk); #1; end
    end
    exp_q.delete();
    #1 reset = 1'b1;
    #1;
    compared++;
    if (obs !== VecIdle) begin
      mismatched++;
      $display("FAIL reset_mid_async: got %b expected %b", obs, VecIdle);
    end
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    compared++;
    if (obs !== VecIdle) begin
      mismatched++;
      $display("FAIL reset_mid_idle: got %b expected %b", obs, VecIdle);
    end
  endtask

  initial begin
    test_reset();
    test_mask(3'b111);
    test_mask(3'b101);
    test_mask(3'b000);
    test_mask(3'b010);
    test_mask(3'b110);
    test_start_ignored();
    test_abort();
    test_reset_mid();
    test_mask(3'b111);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
